// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: MMIO register offsets, STATUS bit positions and UART TX state encoding
// shared by mmio_uart_tx and uart_tx_core.
package arch_defs_pkg;
    localparam logic [1:0] MMIO_OFF_TXDATA = 2'd0;
    localparam logic [1:0] MMIO_OFF_STATUS = 2'd1;
    localparam logic [1:0] MMIO_OFF_LED    = 2'd2;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: serialiser (8N1, or 8E1 when MMIO_UART_PARITY_EN is defined) that pulls
// bytes through a valid/ready pop interface.
module uart_tx_core
    import arch_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pop_valid,
    input  logic [7:0] pop_data,
    output logic       pop_ready,
    output logic       uart_tx,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    uart_tx_state_t state, state_n;
    logic [CW-1:0] baud_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic tc;
    assign tc = baud_cnt == CW'(CLKS_PER_BIT - 1);
    assign busy = state != IDLE;
`ifdef MMIO_UART_PARITY_EN
    logic parity;
    always_ff @(posedge clk) begin
        if (!reset) parity <= 1'b0;
        else if (pop_ready) parity <= ^pop_data;
    end
`endif
    always_comb begin
        state_n = state;
        pop_ready = 1'b0;
        uart_tx = 1'b1;
        case (state)
            IDLE: begin
                pop_ready = pop_valid;
                state_n = pop_valid ? START : IDLE;
            end
            START: begin
                uart_tx = 1'b0;
                state_n = tc ? DATA : START;
            end
            DATA: begin
                uart_tx = shift[0];
`ifdef MMIO_UART_PARITY_EN
                state_n = (tc && bit_idx == 3'd7) ? PARITY : DATA;
`else
                state_n = (tc && bit_idx == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                uart_tx = parity;
                state_n = tc ? STOP : PARITY;
            end
`endif
            // Popping at the end of STOP chains frames with no idle gap
            STOP: begin
                pop_ready = tc && pop_valid;
                state_n = tc ? (pop_valid ? START : IDLE) : STOP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            baud_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            baud_cnt <= (state == IDLE || tc) ? '0 : baud_cnt + 1'b1;
            if (pop_ready) begin
                shift <= pop_data;
                bit_idx <= '0;
            end else if (state == DATA && tc) begin
                shift <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO LED latch plus FIFO-buffered UART transmitter with STATUS register.
// Define MMIO_UART_PARITY_EN to send even parity (8E1) instead of 8N1.
module mmio_uart_tx
    import arch_defs_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [11:0]           address,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] led_out,
    output logic                  uart_tx,
    output logic                  tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [1:0] off;
    logic wr, rd, full, empty, push, pop, ovf, ovf_set, ovf_clr, core_busy, unused_addr;
    logic [DATA_WIDTH-1:0] status, rd_data;
    assign off = address[1:0];
    assign unused_addr = ^address[11:2];
    assign wr = ce && we;
    assign rd = ce && re && !we;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A simultaneous pop frees the slot, so a write to a full FIFO still lands
    assign push = wr && off == MMIO_OFF_TXDATA && (!full || pop);
    assign ovf_set = wr && off == MMIO_OFF_TXDATA && full && !pop;
    assign ovf_clr = rd && off == MMIO_OFF_STATUS;
    assign tx_busy = core_busy || !empty;
    always_comb begin
        status = '0;
        status[STAT_BUSY] = tx_busy;
        status[STAT_FULL] = full;
        status[STAT_EMPTY] = empty;
        status[STAT_OVF] = ovf;
    end
    assign rd_data = off == MMIO_OFF_STATUS ? status : off == MMIO_OFF_LED ? led_out : '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf <= 1'b0;
            led_out <= '0;
            data_out <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            ovf <= ovf_set || (ovf && !ovf_clr);
            if (wr && off == MMIO_OFF_LED) led_out <= data_in;
            if (ce && re) data_out <= we ? '0 : rd_data;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in[7:0];
    end
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk(clk),
        .reset(reset),
        .pop_valid(!empty),
        .pop_data(mem[rd_ptr[AW-1:0]]),
        .pop_ready(pop),
        .uart_tx(uart_tx),
        .busy(core_busy)
    );
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized self-checking bench; expected serial frames are built
// from the frame format (start, 8 data LSB first, optional parity, stop).
module tb_mmio_uart_tx;
    localparam int CPB = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    typedef logic [7:0] byte_q_t[$];
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b0, we = 1'b0, re = 1'b0;
    logic [11:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out, led_out;
    logic uart_tx, tx_busy;
    int n_cmp = 0;
    int n_err = 0;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .ce(ce), .address(address), .we(we), .re(re),
        .data_in(data_in), .data_out(data_out), .led_out(led_out),
        .uart_tx(uart_tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] addr_of(input logic [1:0] off);
        logic [9:0] hi;
        hi = 10'($urandom);
        return {hi, off};
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef MMIO_UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic mmio_write(input logic [1:0] off, input logic [7:0] v);
        ce = 1'b1; we = 1'b1; address = addr_of(off); data_in = v;
        cyc();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic write_burst(input byte_q_t q);
        ce = 1'b1; we = 1'b1;
        foreach (q[i]) begin
            address = addr_of(2'd0); data_in = q[i];
            cyc();
        end
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic mmio_read(input logic [1:0] off, output logic [7:0] v);
        ce = 1'b1; re = 1'b1; address = addr_of(off);
        cyc();
        ce = 1'b0; re = 1'b0;
        v = data_out;
    endtask

    task automatic check_frames(input byte_q_t q, input bit check_lat);
        int w, errs, busy_errs;
        w = 0;
        while (uart_tx !== 1'b0 && w < 400) begin
            cyc();
            w++;
        end
        n_cmp++;
        if (uart_tx !== 1'b0) begin
            n_err++;
            $display("FAIL start_timeout uart_tx=%b expected 0", uart_tx);
            return;
        end
        if (check_lat) begin
            n_cmp++;
            if (w != 1) begin
                n_err++;
                $display("FAIL start_latency got %0d cycles expected 1", w);
            end
        end
        foreach (q[i]) begin
            errs = 0; busy_errs = 0;
            for (int k = 0; k < FRAME_BITS * CPB; k++) begin
                if (uart_tx !== frame_bit(q[i], k / CPB)) errs++;
                if (tx_busy !== 1'b1) busy_errs++;
                cyc();
            end
            n_cmp++;
            if (errs != 0) begin
                n_err++;
                $display("FAIL frame_%0d byte=%02h bad_cycles=%0d expected 0", i, q[i], errs);
            end
            n_cmp++;
            if (busy_errs != 0) begin
                n_err++;
                $display("FAIL busy_frame_%0d low_cycles=%0d expected 0", i, busy_errs);
            end
        end
        n_cmp++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after uart_tx=%b tx_busy=%b expected 1/0", uart_tx, tx_busy);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        n_cmp++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || led_out !== 8'h00 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs tx=%b busy=%b led=%02h dout=%02h expected 1/0/00/00",
                     uart_tx, tx_busy, led_out, data_out);
        end
        mmio_read(2'd1, v);
        n_cmp++;
        if (v !== 8'h04) begin
            n_err++;
            $display("FAIL reset_status got %02h expected 04", v);
        end
    endtask

    task automatic test_led();
        logic [7:0] v, exp_led;
        exp_led = 8'h00;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x;
            x = (i == 0) ? 8'hA5 : 8'($urandom);
            mmio_write(2'd2, x);
            exp_led = x;
            n_cmp++;
            if (led_out !== exp_led) begin
                n_err++;
                $display("FAIL led_latch got %02h expected %02h", led_out, exp_led);
            end
            mmio_read(2'd2, v);
            n_cmp++;
            if (v !== exp_led) begin
                n_err++;
                $display("FAIL led_read got %02h expected %02h", v, exp_led);
            end
        end
        mmio_write(2'd3, 8'h3C);
        n_cmp++;
        if (led_out !== exp_led) begin
            n_err++;
            $display("FAIL reserved_write led=%02h expected %02h", led_out, exp_led);
        end
        mmio_read(2'd3, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_err++;
            $display("FAIL reserved_read got %02h expected 00", v);
        end
        mmio_read(2'd0, v);
        n_cmp++;
        if (v !== 8'h00) begin
            n_err++;
            $display("FAIL txdata_read got %02h expected 00", v);
        end
    endtask

    task automatic test_single_frame();
        byte_q_t q;
        q = {8'h55};
        mmio_write(2'd0, 8'h55);
        check_frames(q, 1'b1);
    endtask

    task automatic test_overflow();
        byte_q_t wq, eq;
        logic [7:0] s1, s2;
        wq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        eq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            check_frames(eq, 1'b0);
            begin
                write_burst(wq);
                mmio_read(2'd1, s1);
                mmio_read(2'd1, s2);
            end
        join
        n_cmp++;
        if (s1 !== 8'h0B) begin
            n_err++;
            $display("FAIL ovf_status_first got %02h expected 0b", s1);
        end
        n_cmp++;
        if (s2 !== 8'h03) begin
            n_err++;
            $display("FAIL ovf_status_second got %02h expected 03", s2);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            byte_q_t q;
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            fork
                check_frames(q, 1'b0);
                write_burst(q);
            join
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int bad;
        byte_q_t q;
        mmio_write(2'd0, 8'h0F);
        for (int i = 0; i < 1 + CPB + 2 * CPB + 1; i++) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        n_cmp++;
        if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset tx=%b busy=%b expected 1/0", uart_tx, tx_busy);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0) bad++;
            cyc();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet active_cycles=%0d expected 0", bad);
        end
        mmio_read(2'd1, v);
        n_cmp++;
        if (v !== 8'h04) begin
            n_err++;
            $display("FAIL post_reset_status got %02h expected 04", v);
        end
        q = {8'h07};
        mmio_write(2'd0, 8'h07);
        check_frames(q, 1'b1);
    endtask

    initial begin
        test_reset();
        test_led();
        test_single_frame();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
